result_tx_streamer: RTL

- Parametrised successor to the fixed 4-byte result transmitter in the output domain.
- Accepts DATA_W-bit results through a valid/ready port into a DEPTH-entry FIFO.
- Serialises each result into NBYTES = ceil(DATA_W/8) UART bytes, with byte order selectable per word and a programmable inter-byte gap.
- Sits between the compute core and the UART transmitter (tx_start/tx_busy handshake).

---
 rtl/result_tx_streamer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/result_tx_streamer.sv
// Result byte streamer: buffers DATA_W-bit results in a small FIFO and
// serialises each one into NBYTES UART bytes through a tx_start/tx_busy
// handshake, with selectable byte order and a programmable inter-byte gap.
module result_tx_streamer #(
  parameter int DATA_W           = 32,
  parameter int DEPTH            = 4,
  parameter int INTER_BYTE_DELAY = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       msb_first,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic                       word_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       idle
);

  localparam int NBYTES   = (DATA_W + 7) / 8;
  localparam int SW       = NBYTES * 8;
  localparam int PW       = $clog2(DEPTH);
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int BW       = $clog2(NBYTES + 1);
  localparam int GW       = (INTER_BYTE_DELAY > 0) ? $clog2(INTER_BYTE_DELAY + 1) : 1;
  localparam int GAP_LAST = (INTER_BYTE_DELAY > 0) ? INTER_BYTE_DELAY - 1 : 0;

  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [GW-1:0] GAP_END   = GW'(GAP_LAST);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_HI, WAIT_LO, GAP
  } state_t;

  state_t            state, state_next;
  logic [DATA_W:0]   mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop;
  logic [SW-1:0]     shift_word;
  logic              shift_msb;
  logic [BW-1:0]     byte_idx;
  logic [GW-1:0]     gap_cnt;
  logic              last_byte;
  logic              byte_adv;

  // Byte lane select; the top byte of a padded word carries zeros above DATA_W.
  function automatic logic [7:0] pick_byte(input logic [SW-1:0] w,
                                           input logic          msb,
                                           input logic [BW-1:0] idx);
    logic [BW-1:0] sel;
    sel = msb ? (LAST_BYTE - idx) : idx;
    return w[{sel, 3'b000} +: 8];
  endfunction

  // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO.
  assign in_ready  = (fifo_count < FULL_CNT);
  assign push      = in_valid && in_ready;
  assign last_byte = (byte_idx == LAST_BYTE);
  assign idle      = (state == IDLE) && (fifo_count == '0);

  // FIFO storage: each entry keeps its byte order flag alongside the word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {msb_first, in_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    byte_adv   = 1'b0;
    tx_start   = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD:    state_next = START;
      START: begin
        tx_start   = 1'b1;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          word_done = last_byte;
          if (INTER_BYTE_DELAY == 0) begin
            if (last_byte) begin
              state_next = IDLE;
            end else begin
              byte_adv   = 1'b1;
              state_next = LOAD;
            end
          end else begin
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_END) begin
          if (last_byte) begin
            state_next = IDLE;
          end else begin
            byte_adv   = 1'b1;
            state_next = LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Word shift register, loaded from the FIFO head on pop.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_word <= SW'(mem[rd_ptr][DATA_W-1:0]);
      shift_msb  <= mem[rd_ptr][DATA_W];
    end
  end

  // Byte index, gap counter and the held output byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data  <= '0;
      byte_idx <= '0;
      gap_cnt  <= '0;
    end else begin
      if (pop)           byte_idx <= '0;
      else if (byte_adv) byte_idx <= byte_idx + BW'(1);
      if (state == LOAD) tx_data <= pick_byte(shift_word, shift_msb, byte_idx);
      if ((state != GAP) && (state_next == GAP)) gap_cnt <= '0;
      else if (state == GAP)                     gap_cnt <= gap_cnt + GW'(1);
    end
  end

endmodule
